// File: rtl/mvau_wmem_pkg.sv
// Shared types for the runtime-loadable MVAU weight memory.
// Load/serve FSM states and the read-latency legality helper.
package mvau_wmem_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2
  } wmem_state_e;

  // Only a bare BRAM read (1) or BRAM read plus output register (2) is supported.
  function automatic bit rd_lat_legal(input int lat);
    return (lat == 1) || (lat == 2);
  endfunction

endpackage

// File: rtl/mvau_wmem_bank.sv
// One PE weight bank: single write port, single synchronous read port,
// optional output register so the whole read path maps onto a block RAM.
module mvau_wmem_bank #(
  parameter int WIDTH   = 2,
  parameter int DEPTH   = 4,
  parameter int ADDR_BW = 2,
  parameter bit OUT_REG = 1'b0
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               we,
  input  logic [ADDR_BW-1:0] waddr,
  input  logic [WIDTH-1:0]   wdata,
  input  logic               re,
  input  logic               clr,
  input  logic [ADDR_BW-1:0] raddr,
  input  logic               out_en,
  output logic [WIDTH-1:0]   rdata
);

  (* ram_style = "auto" *) logic [WIDTH-1:0] mem [0:DEPTH-1];
  logic [WIDTH-1:0] rd_q;

  always_ff @(posedge aclk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // clr models the RAM output-latch reset used for out-of-range reads.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_q <= '0;
    end else if (re) begin
      rd_q <= mem[raddr];
    end else if (clr) begin
      rd_q <= '0;
    end
  end

  if (OUT_REG) begin : g_out_reg
    logic [WIDTH-1:0] out_q;

    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
        out_q <= '0;
      end else if (out_en) begin
        out_q <= rd_q;
      end
    end

    assign rdata = out_q;
  end else begin : g_no_out_reg
    logic unused_out_en;
    assign unused_out_en = out_en;
    assign rdata         = rd_q;
  end

endmodule

// File: rtl/mvau_weight_mem_multi.sv
// Multi-PE weight memory: streamed run-time load (address-major, PE-minor)
// followed by parallel reads of all banks with RD_LAT-cycle latency.
module mvau_weight_mem_multi
  import mvau_wmem_pkg::*;
#(
  parameter int PE           = 2,
  parameter int SIMD         = 2,
  parameter int TW           = 1,
  parameter int WMEM_DEPTH   = 4,
  parameter int WMEM_ADDR_BW = 2,
  parameter int RD_LAT       = 1
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [SIMD*TW-1:0]         s_wload_tdata,
  input  logic                       s_wload_tvalid,
  output logic                       s_wload_tready,
  input  logic                       wmem_rd_en,
  input  logic [WMEM_ADDR_BW-1:0]    wmem_addr,
  output logic [PE*SIMD*TW-1:0]      wmem_out,
  output logic                       wmem_valid,
  output logic                       wmem_loaded,
  output logic                       wmem_addr_err
);

  localparam int WORD_W = SIMD * TW;
  localparam int IDX_BW = (WMEM_DEPTH > 1) ? $clog2(WMEM_DEPTH) : 1;
  localparam int PE_BW  = (PE > 1) ? $clog2(PE) : 1;
  localparam logic [WMEM_ADDR_BW:0] DEPTH_LIM = (WMEM_ADDR_BW + 1)'(WMEM_DEPTH);

  if (!rd_lat_legal(RD_LAT)) begin : g_bad_rd_lat
    $error("mvau_weight_mem_multi: RD_LAT must be 1 or 2");
  end

  wmem_state_e       state, state_nxt;
  logic [PE_BW-1:0]  bank_cnt;
  logic [IDX_BW-1:0] addr_cnt;
  logic [RD_LAT-1:0] vld_pipe, err_pipe;
  logic              beat_acc, last_beat, rd_acc, in_range, in_flight;

  assign s_wload_tready = (state == ST_LOAD);
  assign wmem_loaded    = (state == ST_READY);
  assign beat_acc       = s_wload_tvalid && s_wload_tready;
  assign last_beat      = (bank_cnt == PE_BW'(PE - 1)) && (addr_cnt == IDX_BW'(WMEM_DEPTH - 1));
  assign rd_acc         = (state == ST_READY) && wmem_rd_en;
  assign in_range       = ({1'b0, wmem_addr} < DEPTH_LIM);

  // The final pipe stage is the one presenting data, so it no longer blocks a reload.
  if (RD_LAT == 2) begin : g_flight2
    assign in_flight = vld_pipe[0];
  end else begin : g_flight1
    assign in_flight = 1'b0;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (s_wload_tvalid) state_nxt = ST_LOAD;
      ST_LOAD:  if (beat_acc && last_beat) state_nxt = ST_READY;
      ST_READY: if (s_wload_tvalid && !rd_acc && !in_flight) state_nxt = ST_LOAD;
      default:  state_nxt = ST_EMPTY;
    endcase
  end

  // Counters sit at zero outside LOAD, so every load starts at bank 0, address 0.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      bank_cnt <= '0;
      addr_cnt <= '0;
    end else if (state != ST_LOAD) begin
      bank_cnt <= '0;
      addr_cnt <= '0;
    end else if (beat_acc) begin
      if (bank_cnt == PE_BW'(PE - 1)) begin
        bank_cnt <= '0;
        addr_cnt <= last_beat ? '0 : addr_cnt + IDX_BW'(1);
      end else begin
        bank_cnt <= bank_cnt + PE_BW'(1);
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      vld_pipe <= '0;
      err_pipe <= '0;
    end else begin
      vld_pipe[0] <= rd_acc;
      err_pipe[0] <= rd_acc && !in_range;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        err_pipe[i] <= err_pipe[i-1];
      end
    end
  end

  assign wmem_valid    = vld_pipe[RD_LAT-1];
  assign wmem_addr_err = err_pipe[RD_LAT-1];

  for (genvar p = 0; p < PE; p++) begin : g_bank
    mvau_wmem_bank #(
      .WIDTH   (WORD_W),
      .DEPTH   (WMEM_DEPTH),
      .ADDR_BW (IDX_BW),
      .OUT_REG (RD_LAT == 2)
    ) u_bank (
      .aclk    (aclk),
      .aresetn (aresetn),
      .we      (beat_acc && (bank_cnt == PE_BW'(p))),
      .waddr   (addr_cnt),
      .wdata   (s_wload_tdata),
      .re      (rd_acc && in_range),
      .clr     (rd_acc && !in_range),
      .raddr   (wmem_addr[IDX_BW-1:0]),
      .out_en  (vld_pipe[0]),
      .rdata   (wmem_out[p*WORD_W +: WORD_W])
    );
  end

endmodule

// File: tb/tb_mvau_weight_mem_multi.sv
// Scoreboard bench for mvau_weight_mem_multi (PE=2, SIMD=2, TW=4, DEPTH=4, RD_LAT=2):
// reads push expected words from a bench-side weight model, a negedge monitor pops them.
module tb_mvau_weight_mem_multi;

  localparam int PE    = 2;
  localparam int SIMD  = 2;
  localparam int TW    = 4;
  localparam int DEPTH = 4;
  localparam int ABW   = 3;
  localparam int RDL   = 2;
  localparam int WW    = SIMD * TW;
  localparam int OW    = PE * WW;

  typedef struct {
    logic [OW-1:0] data;
    logic          err;
    int            cyc;
  } rd_exp_t;

  logic           aclk = 1'b0;
  logic           aresetn;
  logic [WW-1:0]  s_wload_tdata;
  logic           s_wload_tvalid;
  logic           s_wload_tready;
  logic           wmem_rd_en;
  logic [ABW-1:0] wmem_addr;
  logic [OW-1:0]  wmem_out;
  logic           wmem_valid;
  logic           wmem_loaded;
  logic           wmem_addr_err;

  int            compared   = 0;
  int            mismatched = 0;
  int            cyc        = 0;
  rd_exp_t       sb[$];
  logic [WW-1:0] model_mem [PE][DEPTH];
  logic [OW-1:0] last_exp = '0;

  mvau_weight_mem_multi #(
    .PE(PE), .SIMD(SIMD), .TW(TW), .WMEM_DEPTH(DEPTH), .WMEM_ADDR_BW(ABW), .RD_LAT(RDL)
  ) dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .s_wload_tdata  (s_wload_tdata),
    .s_wload_tvalid (s_wload_tvalid),
    .s_wload_tready (s_wload_tready),
    .wmem_rd_en     (wmem_rd_en),
    .wmem_addr      (wmem_addr),
    .wmem_out       (wmem_out),
    .wmem_valid     (wmem_valid),
    .wmem_loaded    (wmem_loaded),
    .wmem_addr_err  (wmem_addr_err)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [OW-1:0] expData(input int a);
    logic [OW-1:0] r;
    r = '0;
    if (a < DEPTH) begin
      for (int p = 0; p < PE; p++) r[p*WW +: WW] = model_mem[p][a];
    end
    return r;
  endfunction

  // Monitor: every valid beat must match the oldest outstanding read, on time.
  always @(negedge aclk) begin
    if (aresetn) begin
      if (wmem_valid) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_valid", 1, 0);
        end else begin
          rd_exp_t e;
          e = sb.pop_front();
          checkOutput("rd_data", wmem_out, e.data);
          checkOutput("rd_err", wmem_addr_err, e.err);
          checkOutput("rd_latency", cyc, e.cyc);
          last_exp = e.data;
        end
      end else if (wmem_addr_err) begin
        checkOutput("err_without_valid", 1, 0);
      end
    end
  end

  task automatic applyStimulus(input logic tvalid, input logic [WW-1:0] tdata,
                               input logic rd_en, input logic [ABW-1:0] addr);
    s_wload_tvalid = tvalid;
    s_wload_tdata  = tdata;
    wmem_rd_en     = rd_en;
    wmem_addr      = addr;
  endtask

  task automatic idle(input int n);
    applyStimulus(1'b0, '0, 1'b0, '0);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic issueRead(input int a, input bit expect_acc);
    rd_exp_t e;
    applyStimulus(1'b0, '0, 1'b1, ABW'(a));
    if (expect_acc) begin
      e.data = expData(a);
      e.err  = (a >= DEPTH);
      e.cyc  = cyc + RDL;
      sb.push_back(e);
    end
    @(posedge aclk);
    #1;
  endtask

  // Presents beats base+k until n are accepted; an optional idle cycle with junk data at gap_at.
  task automatic loadBeats(input logic [WW-1:0] base, input int n, input int gap_at, input bit rd_noise);
    int  k = 0;
    int  budget = 0;
    bit  gap_done = 0;
    bit  accepted;
    while (k < n && budget < 64) begin
      budget++;
      if (k == gap_at && !gap_done) begin
        gap_done = 1;
        applyStimulus(1'b0, 8'hEE, rd_noise, 3'd1);
        @(posedge aclk);
        #1;
        checkOutput("tready_idle_gap", s_wload_tready, 1);
      end else begin
        applyStimulus(1'b1, base + WW'(k), rd_noise, 3'd1);
        accepted = s_wload_tready;
        if (accepted) checkOutput("loaded_during_load", wmem_loaded, 0);
        @(posedge aclk);
        #1;
        if (accepted) begin
          model_mem[k % PE][k / PE] = base + WW'(k);
          k++;
        end
      end
    end
    if (k < n) checkOutput("load_timeout", k, n);
    applyStimulus(1'b0, '0, 1'b0, '0);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_out"}, wmem_out, 0);
    checkOutput({tag, "_valid"}, wmem_valid, 0);
    checkOutput({tag, "_loaded"}, wmem_loaded, 0);
    checkOutput({tag, "_err"}, wmem_addr_err, 0);
    checkOutput({tag, "_tready"}, s_wload_tready, 0);
  endtask

  initial begin
    aresetn = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, '0);
    repeat (3) @(posedge aclk);
    #1;
    checkIdleOutputs("reset");
    aresetn = 1'b1;

    // Reads in EMPTY are dropped
    issueRead(0, 0);
    idle(3);

    // EMPTY -> LOAD consumes no beat; load 0x10..0x17 with an idle gap
    applyStimulus(1'b1, 8'h10, 1'b0, '0);
    checkOutput("tready_empty", s_wload_tready, 0);
    @(posedge aclk);
    #1;
    checkOutput("tready_load", s_wload_tready, 1);
    loadBeats(8'h10, PE * DEPTH, 3, 0);
    checkOutput("loaded_set1", wmem_loaded, 1);
    checkOutput("tready_ready", s_wload_tready, 0);

    issueRead(0, 1);
    idle(1);
    issueRead(3, 1);
    idle(4);

    for (int a = 0; a < DEPTH; a++) issueRead(a, 1);
    idle(4);
    checkOutput("hold_out", wmem_out, last_exp);
    checkOutput("hold_valid", wmem_valid, 0);

    issueRead(5, 1);
    idle(4);
    checkOutput("hold_after_err", wmem_out, 0);
    checkOutput("err_cleared", wmem_addr_err, 0);

    // Reload request together with a read: read completes first
    applyStimulus(1'b1, 8'h40, 1'b1, 3'd2);
    begin
      rd_exp_t e;
      e.data = expData(2);
      e.err  = 1'b0;
      e.cyc  = cyc + RDL;
      sb.push_back(e);
    end
    checkOutput("defer_tready_t0", s_wload_tready, 0);
    @(posedge aclk);
    #1;
    wmem_rd_en = 1'b0;
    checkOutput("defer_tready_t1", s_wload_tready, 0);
    @(posedge aclk);
    #1;
    checkOutput("defer_tready_t2", s_wload_tready, 0);
    @(posedge aclk);
    #1;
    checkOutput("reload_tready", s_wload_tready, 1);
    checkOutput("reload_loaded", wmem_loaded, 0);
    loadBeats(8'h40, PE * DEPTH, -1, 1);
    checkOutput("loaded_set2", wmem_loaded, 1);
    for (int a = 0; a < DEPTH; a++) issueRead(a, 1);
    issueRead(7, 1);
    idle(4);

    // Reset in the middle of a load
    loadBeats(8'h60, 3, -1, 0);
    aresetn = 1'b0;
    #2;
    checkIdleOutputs("mid_load_reset");
    sb.delete();
    @(posedge aclk);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    issueRead(1, 0);
    issueRead(2, 0);
    idle(3);
    checkOutput("loaded_after_reset", wmem_loaded, 0);

    applyStimulus(1'b1, 8'h80, 1'b0, '0);
    checkOutput("tready_empty2", s_wload_tready, 0);
    @(posedge aclk);
    #1;
    loadBeats(8'h80, PE * DEPTH, 5, 1);
    checkOutput("loaded_set3", wmem_loaded, 1);
    for (int a = 0; a < DEPTH; a++) issueRead(a, 1);
    idle(5);

    checkOutput("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mvau_weight_mem_multi.md
Name: mvau_weight_mem_multi

Overview:
Runtime-loadable, multi-PE weight memory for the MVAU batch/stream datapath; successor to the per-PE, $readmemh-initialised weight ROMs.
- Holds PE banks of WMEM_DEPTH words of SIMD*TW bits each.
- Weights are loaded at run time over a stream interface.
- Serves all PE banks in parallel on a read port with configurable read latency and a valid flag.
- Sits between the weight-load DMA stream and the MVAU compute lanes.

Parameters:
PE, 2, number of processing elements (banks); output width is PE*SIMD*TW
SIMD, 2, weights per bank word
TW, 1, weight bit width
WMEM_DEPTH, 4, words per bank (KDim^2*IFMCh*OFMCh/(SIMD*PE))
WMEM_ADDR_BW, 2, address width; must satisfy 2^WMEM_ADDR_BW >= WMEM_DEPTH
RD_LAT, 1, read latency in cycles; legal values 1 or 2 (2 adds an output register)

Ports:
aclk  in  1  clock; all logic on rising edge
aresetn  in  1  asynchronous, active-low reset
s_wload_tdata  in  SIMD*TW  one bank word per beat
s_wload_tvalid  in  1  load beat valid
s_wload_tready  out  1  load beat accepted when tvalid&tready
wmem_rd_en  in  1  read request
wmem_addr  in  WMEM_ADDR_BW  read address
wmem_out  out  PE*SIMD*TW  read data; bank p occupies bits [(p+1)*SIMD*TW-1 : p*SIMD*TW]
wmem_valid  out  1  wmem_out valid, exactly RD_LAT cycles after an accepted read
wmem_loaded  out  1  a complete weight set is resident
wmem_addr_err  out  1  one-cycle pulse, aligned with wmem_valid, for an out-of-range read

Behaviour:
- Reset (asynchronous, aresetn=0):
  - FSM goes to EMPTY; load counters cleared.
  - wmem_out=0, wmem_valid=0, wmem_loaded=0, wmem_addr_err=0, s_wload_tready=0.
  - Read pipeline flushed. Memory contents are not reset.
- FSM states EMPTY, LOAD, READY:
  - EMPTY: s_wload_tready=0, reads ignored. First cycle with s_wload_tvalid=1 moves the FSM to LOAD; no beat is consumed in that cycle.
  - LOAD: s_wload_tready=1; each accepted beat writes one word.
    - Beat ordering is address-major, PE-minor: beat k writes bank (k mod PE), address (k div PE).
    - The bank counter wraps at PE-1 and then increments the address counter.
    - After beat WMEM_DEPTH*PE-1 is accepted, the next cycle enters READY, sets wmem_loaded=1 and drops tready.
    - Reads are ignored in LOAD; wmem_loaded=0 throughout.
  - READY:
    - A read is accepted when wmem_rd_en=1.
    - s_wload_tvalid=1 with no read accepted this cycle and no read in flight moves the FSM to LOAD. Transition cycle: tready=0, wmem_loaded cleared, counters reset to 0.
    - If a read is accepted or in flight, reload is deferred: read has priority and tready stays 0 until the pipeline drains.
- Read timing:
  - An accepted read at cycle t gives wmem_valid=1 and wmem_out=all banks[addr] at cycle t+RD_LAT.
  - Reads are fully pipelined: one per cycle, no bubbles.
  - wmem_out holds its last value while wmem_valid=0.
- Out-of-range read (addr >= WMEM_DEPTH): wmem_out=0, wmem_valid=1, wmem_addr_err=1 for that one cycle.
- wmem_rd_en in EMPTY or LOAD: no valid, no error, and no side effects.
- A single write port and single read port per bank; loads and reads never overlap, so no read-during-write hazard exists.
- A reset during LOAD leaves a partial set; wmem_loaded stays 0 until a full reload completes.
- Storage inference: ram_style "auto"; the RD_LAT=2 output register must be absorbable into BRAM.

Decomposition:
- Package mvau_wmem_pkg: FSM state enum (EMPTY, LOAD, READY) and the RD_LAT legality check.
- Sub-module mvau_wmem_bank (SIMD*TW x WMEM_DEPTH, 1 write + 1 sync read port), instantiated PE times in a generate loop.
- The top holds the FSM, load counters and read-valid pipeline.

Test Plan:
- Reset then load PE=2, SIMD=2, TW=4, DEPTH=4: 8 beats 0x10..0x17 -> wmem_loaded=1 one cycle after last beat; read addr 0 -> wmem_out=0x1110, addr 3 -> 0x1716, each valid after RD_LAT.
- Back-to-back reads addr 0,1,2,3 every cycle, RD_LAT=2 -> wmem_valid high 4 consecutive cycles starting cycle t+2, data in order.
- Read addr 5 with DEPTH=4 -> wmem_out=0, wmem_valid=1, wmem_addr_err=1 for one cycle.
- tvalid asserted the same cycle as rd_en in READY -> read completes normally; tready stays 0 until valid returns, then LOAD entered and wmem_loaded=0.
- Deassert aresetn after 3 load beats -> all outputs 0 immediately; after release, reads ignored until a full 8-beat reload.
- tvalid toggling 1,0,1 during LOAD -> only beats with tvalid&tready written, counters do not advance on idle cycles.
